// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types: instruction/PC widths, queue entry layout, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_fetch_pkg;

  // Default instruction address width; fetch addresses wrap modulo 2^PC_W.
  localparam int PC_W    = 4;
  // Default instruction word width.
  localparam int INSTR_W = 8;

  // Address fetched first after reset.
  localparam logic [PC_W-1:0] RESET_PC = '0;

  // One prefetched instruction tagged with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries with single-cycle flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pop is ignored while empty; a push while full with no pop is discarded.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head_dat,
  output logic                     head_vld,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             vld_q, vld_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic full_w;
  logic do_pop;
  logic do_push;

  // Qualify requests: flush wins over everything, a full queue accepts a push only alongside a pop.
  always_comb begin
    full_w  = (count_q == CNT_W'(DEPTH));
    do_pop  = pop & vld_q & ~flush;
    do_push = push & ~flush & (~full_w | do_pop);
  end

  // Pointer, count and head-valid next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    // Head-valid is kept as its own flop so the consumer sees a registered valid.
    vld_d = (count_d != '0);
  end

  // Storage next state: only the slot under the write pointer changes.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_dat;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      mem_q    <= mem_d;
    end
  end

  // Head is forced to zero when empty so stale words never leak to the core.
  always_comb begin
    head_dat = vld_q ? mem_q[rd_ptr_q] : '0;
    head_vld = vld_q;
    full     = full_w;
    count    = count_q;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: issues sequential imem requests, queues responses with their PC, presents head to core.
// Latency: request in cycle N with 1-cycle memory gives ir_valid in cycle N+2; 1 instr/cycle steady state.
// Backpressure: requests issue only while queued + in-flight entries stay within DEPTH; ir_ready stalls drain.
module instr_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = cpu_fetch_pkg::PC_W,
  parameter int INSTR_W = cpu_fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic [PC_W:0]      occupancy,
  output logic               overflow_err
);

  import cpu_fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  // Architectural state.
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  // Queue interface.
  entry_t           push_dat;
  entry_t           head_dat;
  logic             head_vld;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  // Per-cycle decisions.
  logic             pop_req;
  logic             fifo_pop;
  logic             issue;
  logic             push;
  logic             drop_rsp;
  logic [SUM_W-1:0] committed;

  // Credit check: queued + in-flight, less the entry leaving this cycle, must leave room for one more.
  always_comb begin
    pop_req   = head_vld & ir_ready;
    committed = SUM_W'(fifo_count) + SUM_W'(outstanding_q) - SUM_W'(pop_req);
    issue     = ~reset & ~halt & ~redirect & (committed < SUM_W'(DEPTH));
  end

  // Response steering: a redirect kills the arriving word, otherwise pending drops consume it first.
  always_comb begin
    push           = imem_rvalid & ~redirect & (drop_cnt_q == '0);
    drop_rsp       = imem_rvalid & ~redirect & (drop_cnt_q != '0);
    fifo_pop       = pop_req & ~redirect;
    push_dat.instr = imem_rdata;
    push_dat.pc    = rsp_pc_q;
  end

  // Next-state for fetch/response PCs, in-flight tracking and the sticky overflow flag.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
    drop_cnt_d    = drop_cnt_q - CNT_W'(drop_rsp);
    overflow_d    = overflow_q | (push & fifo_full & ~fifo_pop);

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      // Everything still in flight after this edge belongs to the abandoned path.
      drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (push)  rsp_pc_d   = rsp_pc_q + PC_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .head_vld (head_vld),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // Output mapping.
  always_comb begin
    imem_req     = issue;
    imem_addr    = fetch_pc_q;
    ir_valid     = head_vld;
    ir           = head_dat.instr;
    ir_pc        = head_dat.pc;
    occupancy    = (PC_W+1)'(fifo_count);
    overflow_err = overflow_q;
  end

endmodule
